// File: rtl/pc_fetch_unit.sv
// Instruction-fetch front end: owns the PC, resolves redirect targets and loads
// the IF/ID pipeline register under a BOOT/RUN/HOLD/REDIR control FSM.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [1:0]  ControlSel,
  input  logic [31:0] BranchPC4,
  input  logic [31:0] BranchImm,
  input  logic [31:0] A,
  input  logic [25:0] JAddress,
  input  logic [31:0] InstrIn,
  output logic [31:0] IMemAddr,
  output logic [31:0] IF_ID_PC4,
  output logic [31:0] IF_ID_Instr,
  output logic        IF_ID_Valid,
  output logic        Busy
);

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_HOLD,
    ST_REDIR
  } state_t;

  localparam logic [31:0] STEP = 32'(PC_STEP);

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] pc4_reg, pc4_next;
  logic [31:0] instr_reg, instr_next;
  logic        valid_reg, valid_next;

  logic [31:0] seq_pc;
  logic [31:0] target;

  assign seq_pc = pc_reg + STEP;

  // Reserved select value 3 falls back to the branch target.
  always_comb begin
    target = BranchPC4 + (BranchImm << 2);
    case (ControlSel)
      2'd1:    target = A;
      2'd2:    target = {BranchPC4[31:28], JAddress, 2'b00};
      default: target = BranchPC4 + (BranchImm << 2);
    endcase
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    pc4_next   = pc4_reg;
    instr_next = instr_reg;
    valid_next = valid_reg;

    case (state_reg)
      ST_BOOT: begin
        valid_next = 1'b0;
        state_next = ST_RUN;
      end

      ST_RUN, ST_HOLD: begin
        if (Redirect) begin
          // Flush clears the instruction and valid bit; the stale PC4 is left as is.
          pc_next    = target;
          instr_next = 32'h0;
          valid_next = 1'b0;
          state_next = ST_REDIR;
        end else if (Stall) begin
          state_next = ST_HOLD;
        end else begin
          pc_next    = seq_pc;
          pc4_next   = seq_pc;
          instr_next = InstrIn;
          valid_next = 1'b1;
          state_next = ST_RUN;
        end
      end

      ST_REDIR: begin
        // Nothing valid sits in IF/ID here, so Stall has nothing to protect.
        if (Redirect) begin
          pc_next    = target;
          instr_next = 32'h0;
          valid_next = 1'b0;
          state_next = ST_REDIR;
        end else begin
          state_next = ST_RUN;
        end
      end

      default: state_next = ST_BOOT;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg <= ST_BOOT;
      pc_reg    <= RESET_PC;
      pc4_reg   <= 32'h0;
      instr_reg <= 32'h0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      pc4_reg   <= pc4_next;
      instr_reg <= instr_next;
      valid_reg <= valid_next;
    end
  end

  assign IMemAddr    = pc_reg;
  assign IF_ID_PC4   = pc4_reg;
  assign IF_ID_Instr = instr_reg;
  assign IF_ID_Valid = valid_reg;
  assign Busy        = (state_reg != ST_RUN);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a table of per-edge vectors plus hand
// sequences for redirect latency and jump-address target formation.
module tb_pc_fetch_unit;

  logic        Clk = 1'b0;
  logic        Rst, Stall, Redirect;
  logic [1:0]  ControlSel;
  logic [31:0] BranchPC4, BranchImm, A;
  logic [25:0] JAddress;
  logic [31:0] InstrIn;
  logic [31:0] IMemAddr, IF_ID_PC4, IF_ID_Instr;
  logic        IF_ID_Valid, Busy;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  pc_fetch_unit #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .Stall      (Stall),
    .Redirect   (Redirect),
    .ControlSel (ControlSel),
    .BranchPC4  (BranchPC4),
    .BranchImm  (BranchImm),
    .A          (A),
    .JAddress   (JAddress),
    .InstrIn    (InstrIn),
    .IMemAddr   (IMemAddr),
    .IF_ID_PC4  (IF_ID_PC4),
    .IF_ID_Instr(IF_ID_Instr),
    .IF_ID_Valid(IF_ID_Valid),
    .Busy       (Busy)
  );

  typedef struct {
    logic        rst, stall, redir;
    logic [1:0]  sel;
    logic [31:0] bpc4, bimm, a;
    logic [25:0] jaddr;
    logic [31:0] instr;
    logic [31:0] e_pc, e_pc4, e_instr;
    logic        e_valid, e_busy;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic rst, input logic stall, input logic redir,
                              input logic [1:0] sel, input logic [31:0] bpc4,
                              input logic [31:0] bimm, input logic [31:0] a,
                              input logic [25:0] jaddr, input logic [31:0] instr,
                              input logic [31:0] e_pc, input logic [31:0] e_pc4,
                              input logic [31:0] e_instr, input logic e_valid,
                              input logic e_busy);
    vec_t v;
    v.rst = rst; v.stall = stall; v.redir = redir; v.sel = sel;
    v.bpc4 = bpc4; v.bimm = bimm; v.a = a; v.jaddr = jaddr; v.instr = instr;
    v.e_pc = e_pc; v.e_pc4 = e_pc4; v.e_instr = e_instr;
    v.e_valid = e_valid; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s row=%0d got=%h want=%h", name, row, got, want);
    end
  endtask

  task automatic drive(input logic rst, input logic stall, input logic redir,
                       input logic [1:0] sel, input logic [31:0] bpc4,
                       input logic [31:0] bimm, input logic [31:0] a,
                       input logic [25:0] jaddr, input logic [31:0] instr);
    Rst = rst; Stall = stall; Redirect = redir; ControlSel = sel;
    BranchPC4 = bpc4; BranchImm = bimm; A = a; JAddress = jaddr; InstrIn = instr;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    int edges;
    drive(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 26'h0, 32'h0);

    //           rst st rd sel bpc4          bimm          a             jaddr   instr           e_pc          e_pc4     e_instr        v  busy
    vq.push_back(mk(1, 0, 0, 0, 0,            0,            0,            0,      0,              32'h0,        32'h0,    32'h0,         0, 1)); // reset
    vq.push_back(mk(0, 0, 0, 0, 0,            0,            0,            0,      32'h1111_1111,  32'h0,        32'h0,    32'h0,         0, 0)); // BOOT edge
    vq.push_back(mk(0, 0, 0, 0, 0,            0,            0,            0,      32'h1111_1111,  32'h4,        32'h4,    32'h1111_1111, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 0,            0,            0,            0,      32'h2222_2222,  32'h8,        32'h8,    32'h2222_2222, 1, 0));
    vq.push_back(mk(0, 0, 1, 0, 32'h20,       32'h3,        0,            0,      32'h3333_3333,  32'h2C,       32'h8,    32'h0,         0, 1)); // branch
    vq.push_back(mk(0, 0, 0, 0, 0,            0,            0,            0,      32'h4444_4444,  32'h2C,       32'h8,    32'h0,         0, 0)); // bubble
    vq.push_back(mk(0, 0, 0, 0, 0,            0,            0,            0,      32'h5555_5555,  32'h30,       32'h30,   32'h5555_5555, 1, 0));
    vq.push_back(mk(0, 0, 1, 1, 0,            0,            32'h400,      0,      0,              32'h400,      32'h30,   32'h0,         0, 1)); // jr
    vq.push_back(mk(0, 0, 1, 2, 32'hA000_0010, 0,           0,            26'h4,  0,              32'hA000_0010, 32'h30,  32'h0,         0, 1)); // j in REDIR
    vq.push_back(mk(0, 1, 0, 0, 0,            0,            0,            0,      0,              32'hA000_0010, 32'h30,  32'h0,         0, 0)); // stall ignored
    vq.push_back(mk(0, 0, 1, 3, 32'h4,        32'h2,        0,            0,      0,              32'hC,        32'h30,   32'h0,         0, 1)); // sel 3 = branch
    vq.push_back(mk(0, 0, 0, 0, 0,            0,            0,            0,      0,              32'hC,        32'h30,   32'h0,         0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0,            0,            0,            0,      32'h6666_6666,  32'h10,       32'h10,   32'h6666_6666, 1, 0));
    for (int i = 0; i < 3; i++)
      vq.push_back(mk(0, 1, 0, 0, 0,          0,            0,            0,      32'h7777_7777,  32'h10,       32'h10,   32'h6666_6666, 1, 1)); // hold
    vq.push_back(mk(0, 0, 0, 0, 0,            0,            0,            0,      32'h8888_8888,  32'h14,       32'h14,   32'h8888_8888, 1, 0)); // release
    vq.push_back(mk(0, 1, 0, 0, 0,            0,            0,            0,      32'h9999_9999,  32'h14,       32'h14,   32'h8888_8888, 1, 1));
    vq.push_back(mk(0, 1, 1, 1, 0,            0,            32'h80,       0,      0,              32'h80,       32'h14,   32'h0,         0, 1)); // redirect from HOLD
    vq.push_back(mk(0, 0, 0, 0, 0,            0,            0,            0,      0,              32'h80,       32'h14,   32'h0,         0, 0));
    vq.push_back(mk(0, 1, 1, 1, 0,            0,            32'hFFFF_FFFC, 0,     0,              32'hFFFF_FFFC, 32'h14,  32'h0,         0, 1)); // stall+redirect in RUN
    vq.push_back(mk(0, 0, 0, 0, 0,            0,            0,            0,      0,              32'hFFFF_FFFC, 32'h14,  32'h0,         0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0,            0,            0,            0,      32'h9999_9999,  32'h0,        32'h0,    32'h9999_9999, 1, 0)); // PC wrap
    vq.push_back(mk(0, 0, 1, 0, 32'h100,      32'hFFFF_FFFF, 0,           0,      0,              32'hFC,       32'h0,    32'h0,         0, 1)); // negative branch
    vq.push_back(mk(1, 0, 1, 1, 0,            0,            32'h300,      0,      0,              32'h0,        32'h0,    32'h0,         0, 1)); // reset in REDIR
    vq.push_back(mk(0, 0, 1, 1, 0,            0,            32'h500,      0,      0,              32'h0,        32'h0,    32'h0,         0, 0)); // BOOT ignores redirect
    vq.push_back(mk(0, 0, 0, 0, 0,            0,            0,            0,      32'hAAAA_AAAA,  32'h4,        32'h4,    32'hAAAA_AAAA, 1, 0));
    vq.push_back(mk(0, 1, 0, 0, 0,            0,            0,            0,      0,              32'h4,        32'h4,    32'hAAAA_AAAA, 1, 1));
    vq.push_back(mk(1, 1, 0, 0, 0,            0,            0,            0,      0,              32'h0,        32'h0,    32'h0,         0, 1)); // reset in HOLD

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].stall, vq[i].redir, vq[i].sel, vq[i].bpc4,
            vq[i].bimm, vq[i].a, vq[i].jaddr, vq[i].instr);
      tick();
      chk("imem_addr", i, IMemAddr, vq[i].e_pc);
      chk("if_id_pc4", i, IF_ID_PC4, vq[i].e_pc4);
      chk("if_id_instr", i, IF_ID_Instr, vq[i].e_instr);
      chk("if_id_valid", i, 32'(IF_ID_Valid), 32'(vq[i].e_valid));
      chk("busy", i, 32'(Busy), 32'(vq[i].e_busy));
      $display("vec %0d: pc=%h pc4=%h instr=%h valid=%b busy=%b",
               i, IMemAddr, IF_ID_PC4, IF_ID_Instr, IF_ID_Valid, Busy);
    end

    // Redirect latency: target instruction lands on the third edge counting the redirect edge.
    drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 26'h0, 32'hBBBB_BBBB);
    tick();
    tick();
    chk("seq_pc4", 100, IF_ID_PC4, 32'h4);
    drive(1'b0, 1'b0, 1'b1, 2'd1, 32'h0, 32'h0, 32'h200, 26'h0, 32'hBBBB_BBBB);
    tick();
    chk("redir_addr", 101, IMemAddr, 32'h200);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 26'h0, 32'hCCCC_CCCC);
    edges = 1;
    while (!IF_ID_Valid && edges < 10) begin
      tick();
      edges++;
    end
    chk("redir_latency", 102, 32'(edges), 32'd3);
    chk("redir_instr", 103, IF_ID_Instr, 32'hCCCC_CCCC);
    chk("redir_pc4", 104, IF_ID_PC4, 32'h204);
    $display("latency seq: edges=%0d pc=%h pc4=%h instr=%h", edges, IMemAddr, IF_ID_PC4, IF_ID_Instr);

    // Jump-address target keeps the top nibble of BranchPC4.
    drive(1'b0, 1'b0, 1'b1, 2'd2, 32'h5123_4560, 32'h0, 32'h0, 26'h3FF_FFFF, 32'h0);
    tick();
    chk("jaddr_target", 105, IMemAddr, 32'h5FFF_FFFC);
    chk("jaddr_busy", 106, 32'(Busy), 32'd1);
    $display("jump seq: pc=%h busy=%b", IMemAddr, Busy);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
